// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial sequencer around an external 1-bit full-adder cell.
// Two WIDTH-bit operands are accepted over a valid/ready handshake and streamed
// LSB-first into the cell, one bit pair per cycle. The running carry is held
// in carry_q, and the sum bits are assembled in res_sh. The parallel result and
// the final carry are then offered over a second valid/ready handshake.
// Optional feature: define SERIAL_SUB_EN to add the op_sub port (A-B mode).
module serial_add_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin_init,
`ifdef SERIAL_SUB_EN
   input  logic             op_sub,
`endif
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_reg;
   state_t           state_next;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             carry_q;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH-1:0] result_reg;
   logic             carry_out_reg;

   logic [WIDTH-1:0] a_sh_next;
   logic [WIDTH-1:0] b_sh_next;
   logic [WIDTH-1:0] res_sh_next;

   logic             accept;
   logic             last_bit;
   logic             b_invert;
   logic             carry_start;

`ifdef SERIAL_SUB_EN
   // Subtract mode latched at accept time so later op_sub changes are ignored.
   logic sub_q;

   // A-B is done as A + ~B + 1: invert the B stream and force the initial carry.
   assign b_invert    = sub_q;
   assign carry_start = op_sub ? 1'b1 : cin_init;
`else
   assign b_invert    = 1'b0;
   assign carry_start = cin_init;
`endif

   // Handshake and status outputs are pure decodes of the state.
   assign in_ready  = (state_reg == ST_IDLE) & ~rst;
   assign out_valid = (state_reg == ST_DONE);
   assign busy      = (state_reg == ST_SHIFT);
   assign result    = result_reg;
   assign carry_out = carry_out_reg;

   assign accept   = in_valid & in_ready;
   assign last_bit = (state_reg == ST_SHIFT) && (cnt == CNT_LAST);

   // Next values of the shift registers. Operands shift right with zero fill.
   // Sum bits enter at the MSB, so after WIDTH shifts bit 0 holds the first sum bit.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
         assign a_sh_next[gi]   = a_sh[gi+1];
         assign b_sh_next[gi]   = b_sh[gi+1];
         assign res_sh_next[gi] = res_sh[gi+1];
      end
   endgenerate
   assign a_sh_next[WIDTH-1]   = 1'b0;
   assign b_sh_next[WIDTH-1]   = 1'b0;
   assign res_sh_next[WIDTH-1] = fa_sum;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: IDLE -> SHIFT on accept, SHIFT -> DONE after WIDTH bits,
   // DONE -> IDLE when the consumer takes the result.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cnt == CNT_LAST) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Drive the full-adder cell only while shifting; otherwise hold its inputs low.
   always_comb begin
      fa_a   = 1'b0;
      fa_b   = 1'b0;
      fa_cin = 1'b0;
      if (state_reg == ST_SHIFT) begin
         fa_a   = a_sh[0];
         fa_b   = b_sh[0] ^ b_invert;
         fa_cin = carry_q;
      end
   end

   // Operand capture and bit-serial datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
      end else begin
         if (accept) begin
            a_sh    <= op_a;
            b_sh    <= op_b;
            res_sh  <= '0;
            carry_q <= carry_start;
            cnt     <= '0;
         end else if (state_reg == ST_SHIFT) begin
            a_sh    <= a_sh_next;
            b_sh    <= b_sh_next;
            res_sh  <= res_sh_next;
            carry_q <= fa_cout;
            if (cnt == CNT_LAST) begin
               cnt <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

`ifdef SERIAL_SUB_EN
   // Operation select register, loaded together with the operands.
   always_ff @(posedge clk) begin
      if (rst) begin
         sub_q <= 1'b0;
      end else if (accept) begin
         sub_q <= op_sub;
      end
   end
`endif

   // Result holding register: loaded on the final shift edge, so the value seen
   // in DONE equals res_sh/carry_q and stays put through IDLE until the next DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_reg    <= '0;
         carry_out_reg <= 1'b0;
      end else if (last_bit) begin
         result_reg    <= res_sh_next;
         carry_out_reg <= fa_cout;
      end
   end

endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: self-checking bench for serial_add_seq (WIDTH=8) with a
// behavioural full-adder cell on the fa_* ports. Define SERIAL_SUB_EN to
// exercise subtract mode as well.
module tb_serial_add_seq;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cin_init;
`ifdef SERIAL_SUB_EN
   logic         op_sub;
`endif
   logic         fa_a;
   logic         fa_b;
   logic         fa_cin;
   logic         fa_sum;
   logic         fa_cout;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry_out;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   serial_add_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .cin_init  (cin_init),
`ifdef SERIAL_SUB_EN
      .op_sub    (op_sub),
`endif
      .fa_a      (fa_a),
      .fa_b      (fa_b),
      .fa_cin    (fa_cin),
      .fa_sum    (fa_sum),
      .fa_cout   (fa_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .busy      (busy)
   );

   // External full-adder cell.
   assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] exp_res;
      logic         exp_c;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting on DUT", name);
   endtask

   // Wait (bounded) until in_ready (sel=0) or out_valid (sel=1) is high, sampling 1 after edges.
   task automatic wait_for(input int sel, input string name, output bit ok);
      int n;
      n  = 0;
      ok = 1'b1;
      while (((sel == 0) ? in_ready : out_valid) !== 1'b1 && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (((sel == 0) ? in_ready : out_valid) !== 1'b1) begin
         ok = 1'b0;
         timeout_fail(name);
      end
   endtask

   // Reference model: plain integer arithmetic on the whole operands.
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input logic sub);
      logic [W:0] full;
      if (sub) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      else     full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      return full;
   endfunction

   // One complete transaction: accept, latency/busy checks, result checks, handoff.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, input logic early_ready,
                         input logic [W-1:0] exp_res, input logic exp_c, input string tag);
      bit ok;
      int edges;
      int busy_cnt;
      op_a      = a;
      op_b      = b;
      cin_init  = cin;
`ifdef SERIAL_SUB_EN
      op_sub    = sub;
`endif
      in_valid  = 1'b1;
      out_ready = early_ready;
      wait_for(0, {tag, " in_ready"}, ok);
      if (!ok) begin
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      // Scramble inputs after the accepting edge; they must have no effect.
      in_valid = 1'b0;
      op_a     = W'($urandom);
      op_b     = W'($urandom);
      cin_init = 1'($urandom);
`ifdef SERIAL_SUB_EN
      op_sub   = 1'($urandom);
`endif
      edges    = 0;
      busy_cnt = 0;
      while (out_valid !== 1'b1 && edges < 40) begin
         if (busy === 1'b1) busy_cnt++;
         @(posedge clk);
         #1;
         edges++;
      end
      check({tag, " latency"}, 32'(edges), 32'(W));
      check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(W));
      check({tag, " result"}, 32'(result), 32'(exp_res));
      check({tag, " carry_out"}, 32'(carry_out), 32'(exp_c));
      $display("txn %s: a=0x%02h b=0x%02h cin=%0d sub=%0d -> result=0x%02h carry=%0d (exp 0x%02h/%0d)",
               tag, a, b, cin, sub, result, carry_out, exp_res, exp_c);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, " out_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, " idle_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, " result_held"}, 32'(result), 32'(exp_res));
   endtask

   initial begin
      bit         ok;
      int         acc1;
      int         acc2;
      logic [W:0] m;
      logic       sub_r;

      rst       = 1'b1;
      in_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      cin_init  = 1'b0;
`ifdef SERIAL_SUB_EN
      op_sub    = 1'b0;
`endif
      out_ready = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst result", 32'(result), 32'd0);
      check("rst carry_out", 32'(carry_out), 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd0);
      check("rst fa_bits", 32'({fa_a, fa_b, fa_cin}), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst in_ready", 32'(in_ready), 32'd1);

      // Directed vector table with hand-computed expectations.
      vecs.push_back('{8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0});
      vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
      vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
      vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
      vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
`ifdef SERIAL_SUB_EN
      vecs.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
      vecs.push_back('{8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0});
`endif
      for (int i = 0; i < vecs.size(); i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'(i % 2),
                vecs[i].exp_res, vecs[i].exp_c, $sformatf("vec%0d", i));
      end

      // Back-to-back accepts with in_valid and out_ready held high.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      op_a      = 8'h01;
      op_b      = 8'h02;
      cin_init  = 1'b0;
`ifdef SERIAL_SUB_EN
      op_sub    = 1'b0;
`endif
      wait_for(0, "b2b first in_ready", ok);
      @(posedge clk);
      #1;
      acc1 = cyc;
      op_a = 8'h10;
      op_b = 8'h20;
      wait_for(1, "b2b first out_valid", ok);
      check("b2b first result", 32'(result), 32'h03);
      wait_for(0, "b2b second in_ready", ok);
      @(posedge clk);
      #1;
      acc2     = cyc;
      in_valid = 1'b0;
      check("b2b accept spacing", 32'(acc2 - acc1), 32'(W + 2));
      wait_for(1, "b2b second out_valid", ok);
      check("b2b second result", 32'(result), 32'h30);
      $display("txn b2b: 0x01+0x02 then 0x10+0x20, spacing=%0d, last result=0x%02h", acc2 - acc1, result);
      @(posedge clk);
      #1;
      out_ready = 1'b0;

      // Backpressure in DONE; a stray in_valid pulse must be ignored.
      op_a      = 8'h12;
      op_b      = 8'h34;
      cin_init  = 1'b0;
      in_valid  = 1'b1;
      wait_for(0, "bp in_ready", ok);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_for(1, "bp out_valid", ok);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp out_valid c%0d", i), 32'(out_valid), 32'd1);
         check($sformatf("bp result c%0d", i), 32'(result), 32'h46);
         check($sformatf("bp in_ready c%0d", i), 32'(in_ready), 32'd0);
         in_valid = (i == 2);
         op_a     = 8'h77;
         op_b     = 8'h77;
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp release out_valid", 32'(out_valid), 32'd0);
      check("bp release in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      check("bp stray ignored busy", 32'(busy), 32'd0);
      check("bp result held idle", 32'(result), 32'h46);
      $display("txn backpressure: 0x12+0x34 held 5 cycles -> result=0x%02h", result);

      // Reset mid-SHIFT after 3 shift edges.
      op_a     = 8'hF0;
      op_b     = 8'h0F;
      cin_init = 1'b1;
      in_valid = 1'b1;
      wait_for(0, "mrst in_ready", ok);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mrst busy before", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mrst out_valid", 32'(out_valid), 32'd0);
      check("mrst busy", 32'(busy), 32'd0);
      check("mrst result", 32'(result), 32'd0);
      check("mrst in_ready during rst", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("mrst in_ready after", 32'(in_ready), 32'd1);
      $display("txn mid-shift reset: result=0x%02h busy=%0d", result, busy);
      run_op(8'h55, 8'hAA, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, "post_rst");

      // Randomized transactions against the arithmetic model.
      for (int i = 0; i < 30; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic         rc;
         ra    = W'($urandom);
         rb    = W'($urandom);
         rc    = 1'($urandom);
`ifdef SERIAL_SUB_EN
         sub_r = 1'($urandom);
`else
         sub_r = 1'b0;
`endif
         m = model(ra, rb, rc, sub_r);
         run_op(ra, rb, rc, sub_r, 1'($urandom), m[W-1:0], m[W], $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
